// File: rtl/mem_req_master_if.sv
// mem_req_master_if: request and response valid/ready streams between the fabric and mem_req_master.
// MEM_REQ_MASTER_BURST_EN adds req_len (beats-1).
interface mem_req_master_if #(parameter int AW = 10, parameter int DW = 16);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
`ifdef MEM_REQ_MASTER_BURST_EN
  logic [3:0]    req_len;
  modport master (output req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready,
                  input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready,
                  output req_ready, rsp_valid, rsp_data);
`else
  modport master (output req_valid, req_write, req_addr, req_wdata, rsp_ready,
                  input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_write, req_addr, req_wdata, rsp_ready,
                  output req_ready, rsp_valid, rsp_data);
`endif
endinterface

// File: rtl/mem_req_master.sv
// mem_req_master: turns a request stream into MemGen_16_10 SRAM cycles; reads return through a credit-guarded FIFO.
// Define MEM_REQ_MASTER_BURST_EN to add req_len multi-beat bursts.
module mem_req_master #(
  parameter int AW        = 10,
  parameter int DW        = 16,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  mem_req_master_if.slave bus,
  output logic            chip_en,
  output logic            wr_en,
  output logic            rd_en,
  output logic [AW-1:0]   addr,
  output logic [DW-1:0]   wr_data,
  input  logic [DW-1:0]   rd_data
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t          r_state, w_state_nxt;
  logic            r_live;
  logic            r_chip_en, r_wr_en, r_rd_en;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wr_data;
  logic [RD_LAT-1:0] r_pipe;
  logic [DW-1:0]   r_fifo [RSP_DEPTH];
  logic [PW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_count, w_inflight, w_cred;
  logic            w_acc, w_push, w_pop, w_issue, w_wr;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
`ifdef MEM_REQ_MASTER_BURST_EN
  logic [3:0]      r_left, w_left_nxt;
  logic            r_b_wr;
`endif
  assign chip_en = r_chip_en;
  assign wr_en   = r_wr_en;
  assign rd_en   = r_rd_en;
  assign addr    = r_addr;
  assign wr_data = r_wr_data;
  // Every read between accept and FIFO push already owns a FIFO slot.
  assign w_inflight    = CW'($countones({r_pipe, r_rd_en}));
  assign w_cred        = CW'(RSP_DEPTH) - r_count - w_inflight;
  assign bus.req_ready = r_live && r_state == IDLE && w_cred != '0;
  assign w_acc         = bus.req_valid && bus.req_ready;
  assign w_push        = r_pipe[RD_LAT-1];
  assign bus.rsp_valid = r_count != '0;
  assign w_pop         = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_data  = bus.rsp_valid ? r_fifo[r_rp] : '0;
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = w_acc;
    w_wr        = bus.req_write;
    w_addr      = bus.req_addr;
    w_wdata     = bus.req_wdata;
`ifdef MEM_REQ_MASTER_BURST_EN
    w_left_nxt  = r_left;
    if (r_state == IDLE) begin
      w_state_nxt = (w_acc && bus.req_len != '0) ? BURST : IDLE;
      w_left_nxt  = w_acc ? bus.req_len : r_left;
    end else begin
      w_issue     = r_b_wr || w_cred != '0;
      w_wr        = r_b_wr;
      w_addr      = r_addr + 1'b1;
      w_wdata     = r_wr_data;
      w_left_nxt  = w_issue ? r_left - 1'b1 : r_left;
      w_state_nxt = (w_issue && r_left == 4'd1) ? IDLE : BURST;
    end
`endif
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_state   <= IDLE;
      r_live    <= 1'b0;
      r_chip_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_pipe    <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_live    <= 1'b1;
      r_chip_en <= w_issue;
      r_wr_en   <= w_issue && w_wr;
      r_rd_en   <= w_issue && !w_wr;
      r_addr    <= w_issue ? w_addr : r_addr;
      r_wr_data <= w_issue ? w_wdata : r_wr_data;
      r_pipe    <= RD_LAT'({r_pipe, r_rd_en});
      r_wp      <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp      <= w_pop ? r_rp + 1'b1 : r_rp;
      r_count   <= r_count + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge clock)
    if (w_push) r_fifo[r_wp] <= rd_data;
`ifdef MEM_REQ_MASTER_BURST_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_left <= '0;
      r_b_wr <= 1'b0;
    end else begin
      r_left <= w_left_nxt;
      r_b_wr <= w_acc ? bus.req_write : r_b_wr;
    end
`endif
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(w_push && !w_pop && r_count == CW'(RSP_DEPTH)));
  a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(w_pop && r_count == '0));
endmodule

// File: tb/tb_mem_req_master.sv
// tb_mem_req_master: directed and random traffic against an SRAM model, checked by a memory/queue scoreboard.
module tb_mem_req_master;
  localparam int DEPTH = 4;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic chip_en, wr_en, rd_en;
  logic [9:0]  addr;
  logic [15:0] wr_data, rd_data;
  logic [15:0] sram [1024];
  logic [15:0] ref_mem [1024];
  logic [15:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b1, rnd = 1'b0, live_b = 1'b0;
  bit p_acc = 1'b0, p_wr = 1'b0, hold = 1'b0;
  logic [9:0]  p_a;
  logic [15:0] p_d, prev_d;

  mem_req_master_if #(.AW(10), .DW(16)) bus ();
  mem_req_master #(.AW(10), .DW(16), .RD_LAT(1), .RSP_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .chip_en(chip_en), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data));

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (chip_en && wr_en) sram[addr] <= wr_data;
    if (chip_en && rd_en) rd_data <= sram[addr];
  end

  always @(posedge clock or negedge reset_n) live_b <= reset_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input bit w, input logic [9:0] a, input logic [15:0] d, output int n);
    bit ok;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    do begin
      @(negedge clock);
      ok = bus.req_ready;
      step();
      n++;
      if (rnd) bus.rsp_ready = 1'($urandom_range(0, 1));
    end while (!ok && n < 50);
    bus.req_valid = 1'b0;
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL send_timeout got=%0d exp=1", ok);
    end
  endtask

  // Scoreboard: every accepted request shows up as a strobe next cycle; reads return ref_mem data in order.
  always @(negedge clock) begin
    if (!reset_n || !mon_on) begin
      p_acc = 1'b0;
      hold  = 1'b0;
      if (!reset_n) exp_q.delete();
    end else begin
      chk("chip_en", chip_en, p_acc);
      chk("wr_en", wr_en, p_acc && p_wr);
      chk("rd_en", rd_en, p_acc && !p_wr);
      if (p_acc) chk("addr", addr, p_a);
      if (p_acc && p_wr) chk("wr_data", wr_data, p_d);
      chk("req_ready", bus.req_ready, live_b && exp_q.size() < DEPTH);
      if (hold) begin
        chk("rsp_hold_valid", bus.rsp_valid, 1);
        chk("rsp_hold_data", bus.rsp_data, prev_d);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
        else chk("rsp_data", bus.rsp_data, exp_q.pop_front());
      end
      hold   = bus.rsp_valid && !bus.rsp_ready;
      prev_d = bus.rsp_data;
      p_acc  = bus.req_valid && bus.req_ready;
      p_wr   = bus.req_write;
      p_a    = bus.req_addr;
      p_d    = bus.req_wdata;
      if (p_acc && p_wr) ref_mem[p_a] = p_d;
      else if (p_acc) exp_q.push_back(ref_mem[p_a]);
    end
  end

  initial begin
    int n, t;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
`ifdef MEM_REQ_MASTER_BURST_EN
    bus.req_len = '0;
`endif
    repeat (3) step();
    chk("rst_chip_en", chip_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    reset_n = 1'b1;
    #1 chk("ready_before_edge", bus.req_ready, 0);
    step();
    chk("ready_after_edge", bus.req_ready, 1);

    // Single write
    send(1'b1, 10'h3FF, 16'hA5A5, n);
    chk("t1_chip_en", chip_en, 1);
    chk("t1_wr_en", wr_en, 1);
    chk("t1_rd_en", rd_en, 0);
    chk("t1_addr", addr, 10'h3FF);
    chk("t1_wr_data", wr_data, 16'hA5A5);
    chk("t1_rsp_valid", bus.rsp_valid, 0);
    step();
    chk("t1_idle_chip_en", chip_en, 0);
    chk("t1_addr_hold", addr, 10'h3FF);
    chk("t1_rsp_valid2", bus.rsp_valid, 0);

    // Single read: response three cycles after accept
    send(1'b0, 10'h3FF, 16'h0, n);
    chk("t2_rd_en", rd_en, 1);
    t = 0;
    do begin
      @(negedge clock);
      t++;
      if (t == 2) chk("t2_rd_pulse", rd_en, 0);
    end while (!bus.rsp_valid && t < 10);
    chk("t2_latency", t, 3);
    chk("t2_data", bus.rsp_data, 16'hA5A5);
    step();

    // Credit limit with a stalled consumer
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 10'h3FF;
    n = 0;
    repeat (6) begin @(negedge clock); n += int'(bus.req_ready); step(); end
    chk("t3_accepts", n, 4);
    @(negedge clock);
    chk("t3_full_ready", bus.req_ready, 0);
    step();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    n = 0;
    repeat (4) begin @(negedge clock); n += int'(bus.req_ready); step(); end
    chk("t3_after_pop", n, 1);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (10) step();
    chk("t3_drained", exp_q.size(), 0);

    // Interleaved write/read/write/read
    t = 0;
    for (int i = 0; i < 4; i++) begin
      send(i % 2 == 0, 10'(1 + i / 2), 16'($urandom), n);
      t += n;
    end
    chk("t4_b2b_cycles", t, 4);
    repeat (6) step();
    chk("t4_drained", exp_q.size(), 0);

    // Random traffic
    for (int i = 0; i < 8; i++) send(1'b1, 10'(i), 16'($urandom), n);
    rnd = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), 16'($urandom), n);
      repeat ($urandom_range(0, 2)) begin
        step();
        bus.rsp_ready = 1'($urandom_range(0, 1));
      end
    end
    rnd = 1'b0;
    bus.rsp_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 30) begin step(); t++; end
    chk("rand_drained", exp_q.size(), 0);

    // Reset while a read is in flight
    send(1'b0, 10'h005, 16'h0, n);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_chip_en", chip_en, 0);
    chk("t5_rd_en", rd_en, 0);
    chk("t5_addr", addr, 0);
    chk("t5_req_ready", bus.req_ready, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    chk("t5_ready_before_edge", bus.req_ready, 0);
    repeat (6) begin
      step();
      chk("t5_no_rsp", bus.rsp_valid, 0);
    end

`ifdef MEM_REQ_MASTER_BURST_EN
    // Read burst across the address wrap
    send(1'b1, 10'h3FE, 16'h1111, n);
    send(1'b1, 10'h3FF, 16'h2222, n);
    send(1'b1, 10'h000, 16'h3333, n);
    send(1'b1, 10'h001, 16'h4444, n);
    repeat (2) step();
    mon_on = 1'b0;
    bus.req_len = 4'd3;
    send(1'b0, 10'h3FE, 16'h0, n);
    bus.req_len = '0;
    n = 0;
    t = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i < 4) begin
        chk("t6_chip_en", chip_en, 1);
        chk("t6_rd_en", rd_en, 1);
        chk("t6_addr", addr, 10'(10'h3FE + i));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk("t6_data", bus.rsp_data, ref_mem[10'(10'h3FE + n)]);
        n++;
      end
      step();
    end
    chk("t6_rsp_count", n, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
